// File: rtl/adder_pkg.sv
// Shared state type and sizing helper for the digit-serial adder/subtractor.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int unsigned num_steps(input int unsigned width, input int unsigned digit_w);
        return width / digit_w;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational DIGIT_W-bit ripple adder; c_msb exposes the carry into the top bit.
module chunk_adder #(
    parameter int unsigned DIGIT_W = 2
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout,
    output logic               c_msb
);

    logic c;

    always_comb begin
        c     = cin;
        c_msb = cin;
        sum   = '0;
        for (int unsigned i = 0; i < DIGIT_W; i++) begin
            if (i == DIGIT_W - 1) begin
                c_msb = c;
            end
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_adder_nbit.sv
// Multi-cycle adder/subtractor: processes DIGIT_W bits per clock through a registered
// carry, with a start/busy/done handshake and a held result.
module serial_adder_nbit
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIGIT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NUM_STEPS = num_steps(WIDTH, DIGIT_W);
    localparam int unsigned STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    if (WIDTH % DIGIT_W != 0) begin : g_bad_digit
        $error("serial_adder_nbit: WIDTH must be a multiple of DIGIT_W");
    end

    state_t              state_q;
    logic [WIDTH-1:0]    a_q, b_q, acc_q;
    logic [WIDTH-1:0]    a_d, b_d, acc_d;
    logic                carry_q;
    logic [STEP_W-1:0]   step_q;
    logic [WIDTH-1:0]    sum_q;
    logic                cout_q, ovf_q, busy_q, done_q;

    logic [WIDTH-1:0]    b_ld;
    logic                c_ld;
    logic                last_step;

    logic [DIGIT_W-1:0]  ch_sum;
    logic                ch_cout, ch_cmsb;

    chunk_adder #(.DIGIT_W(DIGIT_W)) u_chunk (
        .a     (a_q[DIGIT_W-1:0]),
        .b     (b_q[DIGIT_W-1:0]),
        .cin   (carry_q),
        .sum   (ch_sum),
        .cout  (ch_cout),
        .c_msb (ch_cmsb)
    );

    // Partial sums enter at the MSB end so the full result is aligned after the last step.
    always_comb begin
        a_d       = a_q >> DIGIT_W;
        b_d       = b_q >> DIGIT_W;
        acc_d     = (acc_q >> DIGIT_W) | (WIDTH'(ch_sum) << (WIDTH - DIGIT_W));
        b_ld      = op_sub ? ~b : b;
        c_ld      = op_sub ? 1'b1 : cin;
        last_step = (step_q == STEP_W'(NUM_STEPS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            step_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_ld;
                        carry_q <= c_ld;
                        acc_q   <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    acc_q   <= acc_d;
                    carry_q <= ch_cout;
                    step_q  <= step_q + 1'b1;
                    if (last_step) begin
                        sum_q   <= acc_d;
                        cout_q  <= ch_cout;
                        ovf_q   <= ch_cout ^ ch_cmsb;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_adder_nbit.md
Name: serial_adder_nbit

Overview:
- Parametrised multi-cycle adder/subtractor, the successor to the fixed-width combinational ripple adder.
- Adds or subtracts two WIDTH-bit operands DIGIT_W bits per clock, using a registered carry between steps.
- Uses a start/busy/done handshake and holds the result until the next operation.
- Sits between board switch/button capture logic and the LED/7-seg display path. It trades latency for a small, parametrisable datapath.

Parameters:
- WIDTH, 8: operand and result width in bits.
- DIGIT_W, 2: bits processed per clock. WIDTH % DIGIT_W must equal 0; otherwise elaboration fails with $error.
- NUM_STEPS, WIDTH/DIGIT_W: localparam; number of compute cycles.

Ports:
- clk     input   1      system clock, rising-edge.
- rst     input   1      synchronous, active-high reset.
- start   input   1      request a new operation; sampled in IDLE and DONE only.
- op_sub  input   1      0 = a + b + cin; 1 = a - b (cin ignored).
- a       input   WIDTH  operand A, sampled with start.
- b       input   WIDTH  operand B, sampled with start.
- cin     input   1      carry-in for add, sampled with start.
- busy    output  1      high while computing.
- done    output  1      one-cycle pulse when the result becomes valid.
- sum     output  WIDTH  result, registered.
- cout    output  1      add: carry-out. sub: 1 = no borrow (a >= b unsigned).
- ovf     output  1      signed two's-complement overflow.

Behaviour:
- Clock and reset: single clock domain; rst is synchronous and active-high.
- Reset:
  - state = IDLE; busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
  - Internal operand, carry and step registers are cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start = 1: load operands, set step counter = 0, go to RUN.
  - RUN: each cycle, add the low DIGIT_W bits of the A and B shift registers plus the carry register.
    - Shift the partial sum in from the MSB end; update the carry register; increment the step counter.
    - After step NUM_STEPS-1, go to DONE.
  - DONE: done = 1 for exactly this cycle.
    - start = 1: reload operands and go to RUN (back-to-back operation); done still pulses this cycle.
    - Otherwise go to IDLE.
- Operand load:
  - A shift register = a.
  - B shift register = op_sub ? ~b : b.
  - Carry register = op_sub ? 1 : cin.
- Latency: done rises on the NUM_STEPS-th rising edge after the edge that sampled start. Back-to-back throughput is one result per NUM_STEPS+1 cycles.
- busy = (state == RUN). start while busy is ignored and does not queue.
- Result registers:
  - sum, cout and ovf update only on the edge entering DONE, and hold until the next DONE or reset.
  - They are never partially updated while busy.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, captured on the final step.
- Operand inputs may change freely after the sampling edge without affecting the result.
- Reset mid-operation: abort immediately; all outputs go to their reset values; no done pulse.
- DIGIT_W == WIDTH: NUM_STEPS = 1; the operation completes with one RUN cycle.

Decomposition:
- Package adder_pkg holds:
  - state_t enum {IDLE, RUN, DONE};
  - the function num_steps(WIDTH, DIGIT_W).
- One sub-module, chunk_adder #(DIGIT_W):
  - combinational DIGIT_W-bit ripple adder.
  - Inputs: a, b, cin. Outputs: sum, cout, and c_msb (carry into its MSB, used for ovf).
- Top level holds the FSM, counter, shift registers and result registers.

Test Plan:
- WIDTH=8, DIGIT_W=2:
  - add, a=0x35, b=0x4A, cin=1 -> sum=0x80, cout=0, ovf=1.
  - busy is high for 4 cycles; done pulses once, 4 edges after the start edge.
- add, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
- Subtraction:
  - sub, a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0.
  - sub, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Handshake:
  - start re-pulsed during RUN with new operands -> ignored; the first result is unchanged.
  - start held high in the DONE cycle with a=0x01, b=0x02 -> a new run begins, and the next done gives 0x03.
  - The result holds steady through IDLE.
- Reset abort: rst asserted during step 2 of a run -> the next cycle shows busy=0, done=0, sum=0, cout=0, ovf=0. No done pulse follows; a subsequent start works normally.
- Parameter sweep:
  - Configurations: (8,8), (16,4) and (12,3).
  - 1000 random operands with random op_sub/cin each, checked against the behavioural model {cout, sum} = a + (op_sub ? ~b : b) + (op_sub ? 1 : cin) and the ovf rule.
  - Verify latency = NUM_STEPS edges in every configuration.
